// File: rtl/imem_pkg.sv
// Shared widths, halt encoding and FSM state type for the instruction-memory responder.
package imem_pkg;
  localparam int AW = 10;
  localparam int DW = 9;
  localparam logic [DW-1:0] HALT_INST = 9'h1FF;

  typedef enum logic [1:0] {
    LOAD,
    READY,
    RUN
  } imem_state_t;
endpackage

// File: rtl/imem_array.sv
// Single-write / single-read synchronous RAM with a registered read port.
// Contents are not reset; read data appears one cycle after the address.
module imem_array #(
  parameter int AW    = 10,
  parameter int DW    = 9,
  parameter int DEPTH = 1 << AW
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/imem_responder.sv
// Instruction-memory responder: sequential program loader, LOAD->READY->RUN sequencing, 1-cycle fetch with HALT past program end.
// Optional IMEM_LOAD_CHECKSUM_EN adds LoadSum, the XOR of all accepted loader words.
module imem_responder #(
  parameter int              AW        = imem_pkg::AW,
  parameter int              DW        = imem_pkg::DW,
  parameter int              DEPTH     = 1 << AW,
  parameter logic [DW-1:0]   HALT_INST = imem_pkg::HALT_INST
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic [AW-1:0] ProgCtr,
  input  logic          Start,
  input  logic          LoadValid,
  input  logic [DW-1:0] LoadData,
  input  logic          LoadLast,
  output logic          LoadReady,
  output logic [DW-1:0] InstOut,
  output logic          InstValid,
  output logic [AW:0]   ProgLen,
  output logic          Done
`ifdef IMEM_LOAD_CHECKSUM_EN
  , output logic [DW-1:0] LoadSum
`endif
);

  import imem_pkg::*;

  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  imem_state_t   state_q, state_d;
  logic [AW-1:0] wr_ptr;
  logic          start_q;
  logic          sel_mem;
  logic [DW-1:0] rd_data;
  logic          load_fire;
  logic          load_end;
  logic          run_active;
  logic          in_range;

  assign load_fire  = (state_q == LOAD) && LoadValid && LoadReady;
  assign load_end   = load_fire && (LoadLast || (wr_ptr == LAST_ADDR));
  // Start high in RUN hands control back to READY, so no fetch is counted that cycle.
  assign run_active = (state_q == RUN) && !Start;
  assign in_range   = ({1'b0, ProgCtr} < ProgLen);

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= LOAD;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      LOAD:    if (load_end) state_d = READY;
      READY:   if (start_q && !Start) state_d = RUN;
      RUN:     if (Start) state_d = READY;
      default: state_d = LOAD;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      start_q   <= 1'b0;
      LoadReady <= 1'b0;
      wr_ptr    <= '0;
      ProgLen   <= '0;
      InstValid <= 1'b0;
      sel_mem   <= 1'b0;
      Done      <= 1'b0;
    end else begin
      start_q   <= Start;
      LoadReady <= (state_d == LOAD);
      if (load_fire) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (load_end) begin
        ProgLen <= {1'b0, wr_ptr} + (AW + 1)'(1);
      end
      InstValid <= run_active;
      sel_mem   <= run_active && in_range;
      Done      <= run_active ? (Done || !in_range) : 1'b0;
    end
  end

  // sel_mem is cleared by reset, so InstOut falls back to HALT immediately.
  assign InstOut = sel_mem ? rd_data : HALT_INST;

`ifdef IMEM_LOAD_CHECKSUM_EN
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      LoadSum <= '0;
    end else if (load_fire) begin
      LoadSum <= LoadSum ^ LoadData;
    end
  end
`endif

  imem_array #(
    .AW    (AW),
    .DW    (DW),
    .DEPTH (DEPTH)
  ) u_array (
    .clk   (Clk),
    .we    (load_fire),
    .waddr (wr_ptr),
    .wdata (LoadData),
    .raddr (ProgCtr),
    .rdata (rd_data)
  );

endmodule

// File: tb/tb_imem_responder.sv
// Self-checking bench for imem_responder: vector table plus scoreboard queue for fetch results.
module tb_imem_responder;
  import imem_pkg::*;

  logic          Clk = 1'b0;
  logic          Reset = 1'b0;
  logic [AW-1:0] ProgCtr = '0;
  logic          Start = 1'b0;
  logic          LoadValid = 1'b0;
  logic [DW-1:0] LoadData = '0;
  logic          LoadLast = 1'b0;
  logic          LoadReady;
  logic [DW-1:0] InstOut;
  logic          InstValid;
  logic [AW:0]   ProgLen;
  logic          Done;
`ifdef IMEM_LOAD_CHECKSUM_EN
  logic [DW-1:0] LoadSum;
`endif

  imem_responder dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .ProgCtr   (ProgCtr),
    .Start     (Start),
    .LoadValid (LoadValid),
    .LoadData  (LoadData),
    .LoadLast  (LoadLast),
    .LoadReady (LoadReady),
    .InstOut   (InstOut),
    .InstValid (InstValid),
    .ProgLen   (ProgLen),
    .Done      (Done)
`ifdef IMEM_LOAD_CHECKSUM_EN
    , .LoadSum (LoadSum)
`endif
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [AW-1:0] pc;
    logic          start;
    logic [DW-1:0] inst;
    logic          vld;
    logic          done;
  } vec_t;

  typedef struct {
    logic [DW-1:0] inst;
    logic          vld;
    logic          done;
  } exp_t;

  exp_t          sb[$];
  int            checks = 0;
  int            errors = 0;
  logic [DW-1:0] mdl [1 << AW];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // Drive one fetch, queue its expectation, and compare it after the edge.
  task automatic step(input logic [AW-1:0] pc, input logic st, input logic [DW-1:0] inst,
                      input logic vld, input logic done);
    exp_t e;
    ProgCtr = pc;
    Start   = st;
    e.inst  = inst;
    e.vld   = vld;
    e.done  = done;
    sb.push_back(e);
    tick();
    if (sb.size() == 0) begin
      chk("sb_empty", 0, 1);
    end else begin
      e = sb.pop_front();
      chk("InstOut", 32'(InstOut), 32'(e.inst));
      chk("InstValid", 32'(InstValid), 32'(e.vld));
      chk("Done", 32'(Done), 32'(e.done));
    end
  endtask

  task automatic load_word(input logic [AW-1:0] addr, input logic [DW-1:0] d, input logic last);
    bit acc = 0;
    int n = 0;
    LoadValid = 1'b1;
    LoadData  = d;
    LoadLast  = last;
    while (!acc && n < 20) begin
      acc = LoadReady;
      tick();
      n++;
    end
    if (!acc) chk("load_timeout", 0, 1);
    mdl[addr] = d;
    LoadValid = 1'b0;
    LoadLast  = 1'b0;
    LoadData  = 9'h1AA;
  endtask

  task automatic do_reset();
    Reset = 1'b0;
    #2;
    chk("rst_LoadReady", 32'(LoadReady), 0);
    chk("rst_ProgLen", 32'(ProgLen), 0);
    chk("rst_InstOut", 32'(InstOut), 32'(HALT_INST));
    tick();
    Reset = 1'b1;
    tick();
    chk("post_rst_LoadReady", 32'(LoadReady), 1);
  endtask

  task automatic start_run();
    Start = 1'b1;
    tick();
    tick();
    Start = 1'b0;
    tick();
  endtask

  initial begin
    #4000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[$];
    logic done_m;
    logic [AW-1:0] pcs[4];

    // Reset state
    #2;
    chk("rst_InstOut", 32'(InstOut), 32'(HALT_INST));
    chk("rst_InstValid", 32'(InstValid), 0);
    chk("rst_Done", 32'(Done), 0);
    chk("rst_LoadReady", 32'(LoadReady), 0);
    chk("rst_ProgLen", 32'(ProgLen), 0);
    tick();
    Reset = 1'b1;
    tick();
    chk("LoadReady_after_rst", 32'(LoadReady), 1);

    // Basic load
    load_word(0, 9'h001, 0);
    load_word(1, 9'h002, 0);
    load_word(2, 9'h003, 1);
    chk("basic_ProgLen", 32'(ProgLen), 3);
    chk("basic_LoadReady_drop", 32'(LoadReady), 0);

    // Loader traffic in READY is ignored
    LoadValid = 1'b1;
    LoadData  = 9'h155;
    repeat (3) tick();
    LoadValid = 1'b0;
    chk("ready_ProgLen", 32'(ProgLen), 3);
    chk("ready_LoadReady", 32'(LoadReady), 0);

    vecs = '{
      '{pc: 10'd0, start: 1'b1, inst: 9'h1FF, vld: 1'b0, done: 1'b0},
      '{pc: 10'd0, start: 1'b1, inst: 9'h1FF, vld: 1'b0, done: 1'b0},
      '{pc: 10'd0, start: 1'b0, inst: 9'h1FF, vld: 1'b0, done: 1'b0},
      '{pc: 10'd0, start: 1'b0, inst: 9'h001, vld: 1'b1, done: 1'b0},
      '{pc: 10'd1, start: 1'b0, inst: 9'h002, vld: 1'b1, done: 1'b0},
      '{pc: 10'd2, start: 1'b0, inst: 9'h003, vld: 1'b1, done: 1'b0},
      '{pc: 10'd3, start: 1'b0, inst: 9'h1FF, vld: 1'b1, done: 1'b1},
      '{pc: 10'd0, start: 1'b0, inst: 9'h001, vld: 1'b1, done: 1'b1},
      '{pc: 10'd0, start: 1'b1, inst: 9'h1FF, vld: 1'b0, done: 1'b0},
      '{pc: 10'd0, start: 1'b0, inst: 9'h1FF, vld: 1'b0, done: 1'b0},
      '{pc: 10'd0, start: 1'b0, inst: 9'h001, vld: 1'b1, done: 1'b0},
      '{pc: 10'd2, start: 1'b0, inst: 9'h003, vld: 1'b1, done: 1'b0},
      '{pc: 10'd3, start: 1'b1, inst: 9'h1FF, vld: 1'b0, done: 1'b0},
      '{pc: 10'd1, start: 1'b0, inst: 9'h1FF, vld: 1'b0, done: 1'b0},
      '{pc: 10'd1, start: 1'b0, inst: 9'h002, vld: 1'b1, done: 1'b0}
    };
    foreach (vecs[i]) begin
      step(vecs[i].pc, vecs[i].start, vecs[i].inst, vecs[i].vld, vecs[i].done);
    end

    // Reset mid-load, then gapped loading
    do_reset();
    for (int i = 0; i < 4; i++) load_word(AW'(i), 9'(9'h0A0 + i), 0);
    Reset = 1'b0;
    #2;
    chk("midload_ProgLen", 32'(ProgLen), 0);
    chk("midload_LoadReady", 32'(LoadReady), 0);
    tick();
    Reset = 1'b1;
    tick();
    chk("midload_LoadReady_rel", 32'(LoadReady), 1);
    for (int i = 0; i < 5; i++) begin
      load_word(AW'(i), 9'(9'h011 + i), 0);
      repeat ((i % 2) + 1) tick();
    end
    load_word(5, 9'h016, 1);
    chk("gap_ProgLen", 32'(ProgLen), 6);
    start_run();
    done_m = 1'b0;
    for (int a = 0; a < 7; a++) begin
      logic [DW-1:0] ei;
      ei = (a < 6) ? mdl[a] : HALT_INST;
      done_m = done_m || (a >= 6);
      step(AW'(a), 1'b0, ei, 1'b1, done_m);
    end

    // Full depth without LoadLast
    do_reset();
    for (int i = 0; i < (1 << AW); i++) load_word(AW'(i), 9'(i * 7 + 3), 0);
    chk("full_ProgLen", 32'(ProgLen), 32'(1 << AW));
    chk("full_LoadReady", 32'(LoadReady), 0);
    start_run();
    pcs = '{10'h3FF, 10'h000, 10'h200, 10'h3FE};
    foreach (pcs[i]) step(pcs[i], 1'b0, mdl[pcs[i]], 1'b1, 1'b0);

    // Reset mid-run returns outputs immediately
    ProgCtr = 10'h005;
    Reset = 1'b0;
    #2;
    chk("midrun_InstValid", 32'(InstValid), 0);
    chk("midrun_InstOut", 32'(InstOut), 32'(HALT_INST));
    chk("midrun_ProgLen", 32'(ProgLen), 0);
    tick();
    Reset = 1'b1;
    tick();

`ifdef IMEM_LOAD_CHECKSUM_EN
    do_reset();
    chk("sum_reset", 32'(LoadSum), 0);
    load_word(0, 9'h0F0, 0);
    load_word(1, 9'h00F, 1);
    chk("sum_loaded", 32'(LoadSum), 32'h0FF);
    LoadValid = 1'b1;
    LoadData  = 9'h123;
    start_run();
    Start = 1'b1;
    tick();
    Start = 1'b0;
    tick();
    LoadValid = 1'b0;
    chk("sum_frozen", 32'(LoadSum), 32'h0FF);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
